// File: rtl/seq_detect_ctrl.sv
// Round-robin scheduler sharing one 1-2-3 symbol-sequence detector between two
// burst requesters; reports per-burst hit counts and per-requester running totals.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's burst
// RUN   | one symbol per cycle applied to the detector (BURST_LEN cycles)
// DONE  | one-cycle completion pulse; hits folded into the winner's total
module seq_detect_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8,
  localparam int HW       = $clog2(BURST_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [2*BURST_LEN-1:0] data0,
  input  logic [2*BURST_LEN-1:0] data1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   busy,
  output logic                   sym_valid,
  output logic [1:0]             sym_out,
  output logic                   match,
  output logic                   done,
  output logic                   done_id,
  output logic [HW-1:0]          hits,
  output logic [CNT_W-1:0]       total0,
  output logic [CNT_W-1:0]       total1
);

  localparam int DW = 2 * BURST_LEN;
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {DET_S0, DET_S1, DET_S2, DET_S3} det_t;

  state_t           state_q, state_d;
  det_t             det_q, det_d, det_step;
  logic [DW-1:0]    shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hits_q, hits_d;
  logic             cur_id_q, cur_id_d;
  logic             done_id_q, done_id_d;
  logic             last_id_q, last_id_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [CNT_W-1:0] total0_q, total0_d;
  logic [CNT_W-1:0] total1_q, total1_d;
  logic [1:0]       sym;
  logic             pick;

  assign sym = shift_q[1:0];

  always_comb begin
    det_step = DET_S0;
    unique case (det_q)
      DET_S0: det_step = (sym == 2'd1) ? DET_S1 : DET_S0;
      DET_S1: det_step = (sym == 2'd2) ? DET_S2 : (sym == 2'd1) ? DET_S1 : DET_S0;
      DET_S2: det_step = (sym == 2'd3) ? DET_S3 : (sym == 2'd1) ? DET_S1 : DET_S2;
      DET_S3: det_step = (sym == 2'd3) ? DET_S3 : (sym == 2'd1) ? DET_S1 : DET_S0;
      default: det_step = DET_S0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hits_d    = hits_q;
    cur_id_d  = cur_id_q;
    done_id_d = done_id_q;
    last_id_d = last_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    total0_d  = total0_q;
    total1_d  = total1_q;
    pick      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          pick      = (req0 && req1) ? ~last_id_q : req1;
          cur_id_d  = pick;
          last_id_d = pick;
          shift_d   = pick ? data1 : data0;
          det_d     = DET_S0;
          cnt_d     = '0;
          idx_d     = IW'(BURST_LEN - 1);
          gnt0_d    = ~pick;
          gnt1_d    = pick;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        det_d   = det_step;
        cnt_d   = cnt_q + HW'(det_step == DET_S3);
        shift_d = shift_q >> 2;
        if (idx_q == '0) begin
          hits_d    = cnt_d;
          done_id_d = cur_id_q;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        if (done_id_q) total1_d = total1_q + CNT_W'(hits_q);
        else           total0_d = total0_q + CNT_W'(hits_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      det_q     <= DET_S0;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      hits_q    <= '0;
      cur_id_q  <= 1'b0;
      done_id_q <= 1'b0;
      last_id_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      total0_q  <= '0;
      total1_q  <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hits_q    <= hits_d;
      cur_id_q  <= cur_id_d;
      done_id_q <= done_id_d;
      last_id_q <= last_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      total0_q  <= total0_d;
      total1_q  <= total1_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = (state_q != ST_IDLE);
  assign sym_valid = (state_q == ST_RUN);
  assign sym_out   = sym_valid ? sym : 2'b00;
  assign match     = (det_q == DET_S3);
  assign done      = (state_q == ST_DONE);
  assign done_id   = done_id_q;
  assign hits      = hits_q;
  assign total0    = total0_q;
  assign total1    = total1_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl (BURST_LEN=4, CNT_W=8).
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, busy, sym_valid, match, done, done_id;
  logic [1:0] sym_out;
  logic [2:0] hits;
  logic [7:0] total0, total1;

  typedef struct packed {
    logic       id;
    logic [2:0] hits;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] exp_total0 = '0;
  logic [7:0] exp_total1 = '0;
  int         total_cnt = 0;
  int         bad_cnt = 0;

  seq_detect_ctrl #(.BURST_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .sym_valid(sym_valid),
    .sym_out(sym_out), .match(match), .done(done), .done_id(done_id),
    .hits(hits), .total0(total0), .total1(total1)
  );

  always #5 clk = ~clk;

  // Completion monitor: every done pulse must match the oldest expected burst.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done) begin
      total_cnt++;
      if (sb_q.size() == 0) begin
        bad_cnt++;
        $display("FAIL done_unexpected: got done_id=%0d hits=%0d, required no done", done_id, hits);
      end else begin
        e = sb_q.pop_front();
        if (done_id !== e.id || hits !== e.hits) begin
          bad_cnt++;
          $display("FAIL done_result: got id=%0d hits=%0d, required id=%0d hits=%0d",
                   done_id, hits, e.id, e.hits);
        end
        if (e.id) exp_total1 = exp_total1 + 8'(e.hits);
        else      exp_total0 = exp_total0 + 8'(e.hits);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    exp_total0 = '0;
    exp_total1 = '0;
    rst_n = 1'b1;
  endtask

  task automatic check_totals(input string tag);
    total_cnt++;
    if (total0 !== exp_total0 || total1 !== exp_total1) begin
      bad_cnt++;
      $display("FAIL %s_totals: got %0d/%0d, required %0d/%0d", tag, total0, total1, exp_total0, exp_total1);
    end
  endtask

  // Called from an IDLE negedge; returns at the IDLE negedge after DONE.
  task automatic run_burst(input logic id, input logic [7:0] d, input logic [2:0] exp_hits);
    int         w;
    logic [7:0] s;
    logic       g;
    sb_q.push_back('{id: id, hits: exp_hits});
    if (id) begin data1 = d; req1 = 1'b1; end
    else    begin data0 = d; req0 = 1'b1; end
    @(negedge clk);
    w = 1;
    g = id ? gnt1 : gnt0;
    while (!g && w < 20) begin
      @(negedge clk);
      w++;
      g = id ? gnt1 : gnt0;
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    total_cnt++;
    if (!g || w != 1) begin
      bad_cnt++;
      $display("FAIL grant_latency: got gnt=%0d after %0d cycles, required gnt=1 after 1 cycle", g, w);
      return;
    end
    total_cnt++;
    if ((id ? gnt0 : gnt1) !== 1'b0 || busy !== 1'b1) begin
      bad_cnt++;
      $display("FAIL grant_exclusive: got other_gnt=%0d busy=%0d, required 0/1", id ? gnt0 : gnt1, busy);
    end
    s = d;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      total_cnt++;
      if (sym_valid !== 1'b1 || sym_out !== s[1:0]) begin
        bad_cnt++;
        $display("FAIL symbol_%0d: got valid=%0d sym=%0d, required valid=1 sym=%0d", k, sym_valid, sym_out, s[1:0]);
      end
      s = s >> 2;
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b1 || sym_valid !== 1'b0) begin
      bad_cnt++;
      $display("FAIL done_cycle: got done=%0d busy=%0d valid=%0d, required 1/1/0", done, busy, sym_valid);
    end
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad_cnt++;
      $display("FAIL idle_after_done: got busy=%0d done=%0d, required 0/0", busy, done);
    end
    check_totals("burst");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({gnt0, gnt1, busy, sym_valid, sym_out, match, done, done_id, hits, total0, total1} !== '0) begin
      bad_cnt++;
      $display("FAIL reset_outputs: got %0h, required 0",
               {gnt0, gnt1, busy, sym_valid, sym_out, match, done, done_id, hits, total0, total1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || gnt0 !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_idle: got busy=%0d gnt0=%0d, required 0/0", busy, gnt0);
    end
    run_burst(1'b0, 8'hF9, 3'd2);
    total_cnt++;
    if (total0 !== 8'd2 || match !== 1'b1) begin
      bad_cnt++;
      $display("FAIL first_burst: got total0=%0d match=%0d, required 2/1", total0, match);
    end
  endtask

  task automatic test_symbols();
    run_burst(1'b0, 8'hE9, 3'd1);
    run_burst(1'b1, 8'h9D, 3'd0);
    run_burst(1'b0, 8'hFF, 3'd0);
    run_burst(1'b1, 8'hF9, 3'd2);
  endtask

  task automatic test_isolation();
    run_burst(1'b0, 8'h09, 3'd0);
    total_cnt++;
    if (match !== 1'b0) begin
      bad_cnt++;
      $display("FAIL isolation_match: got %0d, required 0", match);
    end
    run_burst(1'b0, 8'hFF, 3'd0);
  endtask

  task automatic test_back_to_back();
    int n = 0, cyc = 0, last_g = 0;
    do_reset();
    for (int i = 0; i < 4; i++) sb_q.push_back('{id: 1'(i % 2), hits: 3'd2});
    data0 = 8'hF9;
    data1 = 8'hF9;
    req0 = 1'b1;
    req1 = 1'b1;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (gnt0 || gnt1) begin
        total_cnt++;
        if ((gnt0 && gnt1) || gnt1 !== 1'(n % 2)) begin
          bad_cnt++;
          $display("FAIL tie_grant_%0d: got gnt0=%0d gnt1=%0d, required gnt%0d only", n, gnt0, gnt1, n % 2);
        end
        total_cnt++;
        if (cyc - last_g != ((n == 0) ? 1 : 6)) begin
          bad_cnt++;
          $display("FAIL tie_spacing_%0d: got %0d cycles, required %0d", n, cyc - last_g, (n == 0) ? 1 : 6);
        end
        last_g = cyc;
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    total_cnt++;
    if (n != 4) begin
      bad_cnt++;
      $display("FAIL tie_timeout: got %0d grants, required 4", n);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    repeat (5) @(negedge clk);
    check_totals("tie");
    total_cnt++;
    if (total0 !== 8'd4 || total1 !== 8'd4) begin
      bad_cnt++;
      $display("FAIL tie_equal: got %0d/%0d, required 4/4", total0, total1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 128; i++) run_burst(1'b1, 8'hF9, 3'd2);
    total_cnt++;
    if (total1 !== 8'd0 || total0 !== 8'd0) begin
      bad_cnt++;
      $display("FAIL wrap_total: got total0=%0d total1=%0d, required 0/0", total0, total1);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    data0 = 8'h9D;
    req0 = 1'b1;
    while (!gnt0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total_cnt++;
    if (!gnt0) begin
      bad_cnt++;
      $display("FAIL mid_grant: got gnt0=0, required 1");
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_total0 = '0;
    exp_total1 = '0;
    total_cnt++;
    if ({gnt0, gnt1, busy, sym_valid, sym_out, match, done, done_id, hits, total0, total1} !== '0) begin
      bad_cnt++;
      $display("FAIL mid_reset_outputs: got %0h, required 0",
               {gnt0, gnt1, busy, sym_valid, sym_out, match, done, done_id, hits, total0, total1});
    end
    data0 = 8'hF9;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++;
      $display("FAIL mid_reset_hold: got done=%0d busy=%0d, required 0/0", done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(1'b0, 8'hF9, 3'd2);
    total_cnt++;
    if (total0 !== 8'd2) begin
      bad_cnt++;
      $display("FAIL mid_regrant_total: got %0d, required 2", total0);
    end
  endtask

  initial begin
    test_reset();
    test_symbols();
    test_isolation();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    total_cnt++;
    if (sb_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Scheduler that shares one 1-2-3 symbol-sequence detector between two requesters. Each requester submits a packed burst of 2-bit symbols. A round-robin arbiter grants one burst at a time, and the controller feeds its symbols one per cycle into the embedded detector. For each burst the block reports the number of detector hits, and it keeps a running hit total per requester. It sits between symbol producers and downstream match/statistics logic.

## Interface
- BURST_LEN, 4, symbols per burst (≥1)
- CNT_W, 8, width of per-requester running totals
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  burst request; held high until the matching gnt pulse
- data0 / data1  in  2*BURST_LEN  packed burst; symbol i = data[2i+1:2i], symbol 0 sent first
- gnt0 / gnt1  out  1  one-cycle grant pulse; data is captured on the edge that raises it
- busy  out  1  high from grant through the done cycle
- sym_valid  out  1  a symbol is being applied to the detector this cycle
- sym_out  out  2  symbol currently applied
- match  out  1  detector state == S3 (registered)
- done  out  1  one-cycle burst-complete pulse
- done_id  out  1  requester of the completed burst (0/1)
- hits  out  $clog2(BURST_LEN+1)  hit count of the completed burst; valid when done=1, held afterwards
- total0 / total1  out  CNT_W  running hit totals, wrap modulo 2^CNT_W

## Operation
- Controller FSM states:
  - IDLE: if req0 or req1 is high at the edge, arbitrate, latch the winner's data into a shift register, clear the detector to S0 and the hit counter to 0, then go to RUN with gnt of the winner = 1 for the first RUN cycle.
  - RUN: lasts BURST_LEN cycles. Each cycle sym_valid=1 and sym_out = current symbol; at the cycle's end the detector steps and the register shifts. After the last symbol, go to DONE.
  - DONE: lasts one cycle. done=1, done_id and hits are valid; total[done_id] += hits at the end of this cycle. Then go to IDLE.
- Arbiter:
  - last_id register; reset value 1, so req0 wins the first tie.
  - One request pending: grant it.
  - Both pending: grant the requester ≠ last_id.
  - last_id is updated on every grant.
  - Requests are ignored outside IDLE; a requester simply keeps req high until served.
- Detector transitions are evaluated only while sym_valid=1, on input sym:
  - S0: 1→S1, else S0
  - S1: 2→S2, 1→S1, else S0
  - S2: 3→S3, 1→S1, else S2
  - S3: 3→S3, 1→S1, else S0
- Hit: a sym_valid cycle whose next detector state is S3. A burst has 0..BURST_LEN hits.
- Detector state is cleared at every grant, so bursts never influence each other. Outside RUN the detector holds its state, so match may stay high after a burst.

## Timing
- Reset (asynchronous, any state):
  - FSM→IDLE, detector→S0, last_id=1.
  - Shift register, hit count, totals, hits, done_id and sym_out = 0.
  - All strobes (gnt0/1, busy, sym_valid, done, match) = 0.
  - A burst in flight is discarded with no done. Totals are lost.
- Latency:
  - Request sampled at edge E0 → gnt and the first symbol in the cycle after E0.
  - Symbol k is applied in cycle E0+1+k.
  - done is high in cycle E0+BURST_LEN+1, then one IDLE cycle follows.
  - Throughput: one burst per BURST_LEN+2 cycles.
- match reflects the state after the previous symbol (registered), so it rises in the cycle after the hit symbol is applied.
- busy = 1 during RUN and DONE.
- gnt0 and gnt1 are never both high.
- A req dropped before its grant is simply not served; there is no error.
- Running totals wrap: total = (total + hits) mod 2^CNT_W, with no saturation.

## Test plan
(BURST_LEN=4, CNT_W=8)
- Reset, then req0=1 with data0=8'hF9 (symbols 1,2,3,3) → gnt0 in the cycle after the sampling edge; sym_out sequence 1,2,3,3; done with done_id=0, hits=2; total0=2.
- Symbol handling: data0=8'hE9 (1,2,2,3) → hits=1. data0=8'h9D (1,3,1,2) → hits=0. data0=8'hFF (3,3,3,3) → hits=0.
- Burst isolation: burst 8'h09 (1,2,0,0; ends in S2), then burst 8'hFF → the second burst gives hits=0, because the detector was cleared to S0 at grant.
- Tie arbitration: req0 and req1 held high continuously with the same data → grants alternate 0,1,0,1; done_id alternates; total0 and total1 grow equally; each burst takes 6 cycles.
- Wrap: 128 bursts of 8'hF9 on req1 → total1 = 256 mod 256 = 0 after the last done; total0 stays 0.
- Reset mid-burst: rst_n low during the third RUN cycle → all outputs go to 0 immediately with no done. After release, held req0 is granted again with data0 re-latched.
